// File: rtl/systolic_drain.sv
// systolic_drain: waits WAIT_CYCLES after start, snapshots the flattened
// N*M result bus and streams the words out over a valid/ready handshake.
// Ports: clk, rst (sync, active-low), start, C_in (N*M words, k=N*row+col),
//   busy, out_data, out_index (k), out_valid, out_ready, out_last.
// Option: define SYSTOLIC_DRAIN_COLMAJOR_EN for column-major word order
//   (k = N*(pos mod N) + pos div N); default order is row-major (k = pos).
module systolic_drain #(
  parameter int DATA_WIDTH  = 32,
  parameter int N           = 3,
  parameter int M           = 3,
  parameter int WAIT_CYCLES = 8,
  localparam int IDX_W      = $clog2(N*M)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH*N*M-1:0] C_in,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int NM = N * M;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t                  r_state;
  state_t                  w_nxt;
  logic [7:0]              r_wcnt;
  logic [IDX_W-1:0]        r_pos;
  logic [DATA_WIDTH-1:0]   r_buf [NM];
  logic [IDX_W-1:0]        w_k;
  logic                    w_valid;
  logic                    w_last;
  logic                    w_snap;
  logic                    w_xfer;

`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
  // r_in walks rows (pos mod N), r_out walks columns (pos div N).
  logic [IDX_W-1:0]        r_in;
  logic [IDX_W-1:0]        r_out;
  assign w_k = IDX_W'(N * int'(r_in) + int'(r_out));
`else
  assign w_k = r_pos;
`endif

  assign w_valid = (r_state == S_STREAM);
  assign w_last  = w_valid && (r_pos == IDX_W'(NM - 1));

  always_comb begin
    w_nxt  = r_state;
    w_snap = 1'b0;
    w_xfer = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wcnt == 8'(WAIT_CYCLES - 1)) begin
          w_snap = 1'b1;
          w_nxt  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          w_xfer = 1'b1;
          if (w_last) w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_pos   <= '0;
      for (int k = 0; k < NM; k++) r_buf[k] <= '0;
`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
      r_in    <= '0;
      r_out   <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE) r_wcnt <= '0;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt + 8'd1;
      if (w_snap) begin
        for (int k = 0; k < NM; k++)
          r_buf[k] <= C_in[k*DATA_WIDTH +: DATA_WIDTH];
        r_pos <= '0;
`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
        r_in  <= '0;
        r_out <= '0;
`endif
      end else if (w_xfer && !w_last) begin
        r_pos <= r_pos + 1'b1;
`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
        if (r_in == IDX_W'(N - 1)) begin
          r_in  <= '0;
          r_out <= r_out + 1'b1;
        end else begin
          r_in  <= r_in + 1'b1;
        end
`endif
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign out_data  = w_valid ? r_buf[w_k] : '0;
  assign out_index = w_valid ? w_k : '0;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed bench for systolic_drain (N=M=3, WAIT=8).
// Follows SYSTOLIC_DRAIN_COLMAJOR_EN to pick the expected index order.
module tb_systolic_drain;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [287:0]  C_in;
  logic          busy;
  logic [31:0]   out_data;
  logic [3:0]    out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int n_chk = 0;
  int n_err = 0;

  systolic_drain #(
    .DATA_WIDTH(32), .N(3), .M(3), .WAIT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .C_in(C_in),
    .busy(busy), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_k(input int p);
`ifdef SYSTOLIC_DRAIN_COLMAJOR_EN
    int t[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    return t[p];
`else
    return p;
`endif
  endfunction

  task automatic set_cin(input bit dead);
    for (int k = 0; k < 9; k++)
      C_in[k*32 +: 32] = dead ? 32'hDEADBEEF : 32'(32'h100 + k);
  endtask

  // Pulse start, optionally change C_in / pulse start again during WAIT,
  // and return in the first cycle where out_valid is high.
  task automatic start_drain(input int chg, input bit dv, input int wst);
    int cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!out_valid && cnt < 50) begin
      if (cnt == 0) chk("wait_busy", 64'(busy), 64'd1);
      step();
      cnt++;
      if (cnt == chg) set_cin(dv);
      start = (cnt == wst);
    end
    start = 1'b0;
    chk("latency", 64'(cnt), 64'd8);
  endtask

  task automatic drain(input bit bp, input bit dead,
                       input int abort_at, input bit st_mid);
    int p = 0;
    int cyc = 0;
    int ek;
    logic [31:0] pd = '0;
    logic [3:0]  pi = '0;
    bit pr = 1'b1;
    bit rdy;
    while (p < 9 && cyc < 100) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      start = st_mid && ((p == 2) || out_last);
      chk("valid", 64'(out_valid), 64'd1);
      if (!pr) begin
        chk("hold_data", 64'(out_data), 64'(pd));
        chk("hold_index", 64'(out_index), 64'(pi));
      end
      ek = exp_k(p);
      if (rdy) begin
        chk("index", 64'(out_index), 64'(ek));
        chk("data", 64'(out_data),
            dead ? 64'h0DEADBEEF : 64'(32'h100 + ek));
        chk("last", 64'(out_last), 64'(p == 8));
      end
      pd = out_data;
      pi = out_index;
      pr = rdy;
      step();
      cyc++;
      if (rdy) p++;
      if (abort_at != 0 && p == abort_at) begin
        start = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        return;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("xfers", 64'(p), 64'd9);
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    set_cin(1'b0);
    repeat (3) step();
    chk("rst_busy0", 64'(busy), 64'd0);
    chk("rst_valid0", 64'(out_valid), 64'd0);
    chk("rst_last0", 64'(out_last), 64'd0);
    chk("rst_data0", 64'(out_data), 64'd0);
    chk("rst_index0", 64'(out_index), 64'd0);
    rst = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // basic drain
    start_drain(0, 1'b0, 0);
    drain(1'b0, 1'b0, 0, 1'b0);

    // back-pressure
    step();
    start_drain(0, 1'b0, 0);
    drain(1'b1, 1'b0, 0, 1'b0);

    // C_in changes right after the snapshot edge
    step();
    start_drain(8, 1'b1, 0);
    drain(1'b0, 1'b0, 0, 1'b0);
    set_cin(1'b0);

    // C_in changes one cycle before the snapshot edge
    step();
    start_drain(7, 1'b1, 0);
    drain(1'b0, 1'b1, 0, 1'b0);
    set_cin(1'b0);

    // start pulses in WAIT, in STREAM and on the final transfer
    step();
    start_drain(0, 1'b0, 3);
    drain(1'b0, 1'b0, 0, 1'b1);
    step();
    chk("no_restart1", 64'(busy), 64'd0);
    step();
    chk("no_restart2", 64'(busy), 64'd0);
    start_drain(0, 1'b0, 0);
    drain(1'b0, 1'b0, 0, 1'b0);

    // reset after four transfers, then a clean drain
    step();
    start_drain(0, 1'b0, 0);
    drain(1'b0, 1'b0, 4, 1'b0);
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);
    start_drain(0, 1'b0, 0);
    drain(1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result drain for the N×M systolic MAC array. The block waits a fixed compute latency after a start pulse, snapshots the array's flattened `C_out` bus into an internal buffer, and streams the N·M result words out one per handshake. It sits between the array's result bus and the downstream consumer, such as a memory writer or a test-harness sink.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one result word.
- `N`, 3: array rows.
- `M`, 3: array columns.
- `WAIT_CYCLES`, 8: cycles from start acceptance to snapshot. Legal range is 1 to 255.
- `IDX_W`, `$clog2(N*M)`: width of the index output. This is a localparam.

Ports:
- `clk`, input, 1: the only clock. Everything is on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin a drain.
- `C_in`, input, DATA_WIDTH·N·M: flattened array results. Word k occupies bits [DATA_WIDTH·(k+1)-1 : DATA_WIDTH·k], where k = N·row + col.
- `busy`, output, 1: high in any state other than IDLE.
- `out_data`, output, DATA_WIDTH: the current result word.
- `out_index`, output, IDX_W: the k of the current word.
- `out_valid`, output, 1: a word is being presented.
- `out_ready`, input, 1: the consumer accepts the word.
- `out_last`, output, 1: marks the final word of the drain.

## Operation
States are IDLE, WAIT and STREAM.

- **IDLE**
  - `start`=1 at an edge → WAIT, with `wait_cnt`=0.
  - `start`=0 → stay in IDLE.
- **WAIT**
  - Each edge increments `wait_cnt`.
  - At the edge where `wait_cnt`==WAIT_CYCLES-1:
    - all N·M words of `C_in` are copied into the buffer;
    - the sequence position `pos` is set to 0;
    - the state moves to STREAM.
- **STREAM**
  - `out_valid`=1.
  - `out_data` = buffer[k(pos)] and `out_index` = k(pos).
  - `out_last`=1 exactly when `pos`==N·M-1.
  - A transfer happens at an edge where `out_valid` and `out_ready` are both 1.
  - On a transfer with `pos`<N·M-1, `pos` increments.
  - On a transfer with `out_last`=1, the state moves to IDLE.
- **Ordering, default:** row-major, so k(pos) = pos.
- **`start` outside IDLE** is ignored and is not queued. This includes a `start` on the same edge as the final transfer.
- **Back-pressure:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable.
- **Snapshot isolation:** `C_in` changes after the snapshot edge do not affect the streamed data.
- **Outputs** are driven from registers (state, `pos`, buffer). There is no combinational path from `out_ready` to `out_valid`.

## Timing
- **Reset value of every output:**
  - `busy`=0, `out_valid`=0, `out_last`=0;
  - `out_data`=0, `out_index`=0.
  - State returns to IDLE and the buffer is cleared to 0.
- **Reset mid-WAIT or mid-STREAM** aborts at that edge. `out_valid` is 0 in the following cycle and the partial drain is discarded.
- **Start to first valid:** for a `start` sampled at edge E0:
  - the snapshot takes the `C_in` value present in the cycle before edge E0+WAIT_CYCLES;
  - `out_valid` is first high in the cycle after edge E0+WAIT_CYCLES.
- **Throughput:** one word per cycle when `out_ready` is held high. A full drain is WAIT_CYCLES + N·M cycles from `start` to return to IDLE.
- **After the last transfer:** `out_valid` and `busy` are 0 in the next cycle. A new `start` is accepted one cycle after the drain returns to IDLE.

## Configuration
- The macro is `SYSTOLIC_DRAIN_COLMAJOR_EN`.
- **Defined:** column-major ordering, k(pos) = N·(pos mod N) + (pos div N). The columns are walked outer and the rows inner. With N=M=3 the k sequence is 0,3,6,1,4,7,2,5,8. `out_index` still reports k.
- **Undefined:** row-major ordering, k(pos) = pos.
- All timing is identical in both builds.

## Test plan
- **Basic drain:** N=M=3, WAIT_CYCLES=8, word k of `C_in` = 0x100+k, `start` pulse, `out_ready`=1.
  - `out_valid` rises 8 cycles after `start`.
  - Words 0x100..0x108 appear on consecutive cycles with `out_index` 0..8.
  - `out_last` is high only on 0x108, and `busy` falls after it.
- **Back-pressure:** `out_ready` toggles 1,0,0,1,… during the drain.
  - While `out_ready`=0, `out_data`/`out_index` hold.
  - There are no duplicated or skipped words, and there are still exactly 9 transfers.
- **Snapshot isolation:**
  - `C_in` changes to all 0xDEADBEEF one cycle after the snapshot edge → the stream still carries 0x100+k.
  - `C_in` changes one cycle before the snapshot edge → the stream carries 0xDEADBEEF.
- **`start` while busy:** `start` pulses in WAIT, in STREAM, and on the final-transfer edge.
  - None of them is accepted and no second drain occurs.
  - A `start` two cycles after `busy` falls begins a new drain.
- **Reset mid-stream:** `rst`=0 for one cycle after 4 transfers.
  - The next cycle shows `out_valid`=0, `busy`=0 and `out_data`=0.
  - A following `start` restarts the drain from `out_index`=0.
- **`SYSTOLIC_DRAIN_COLMAJOR_EN` defined:** rerun the basic drain.
  - The `out_index` sequence is 0,3,6,1,4,7,2,5,8, with data 0x100+index.
  - `out_last` is high on index 8.
